// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx_arbiter block.
// Optional channel tagging is controlled by UART_TX_ARB_CHANNEL_TAG_EN.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TAG_LOAD  = 3'd1,
    ST_TAG_WAIT  = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_RISE = 3'd4,
    ST_WAIT_FALL = 3'd5
  } arb_state_e;

  // MSB value that marks a word on the line as a channel tag.
  localparam logic TAG_MARK = 1'b1;

  function automatic int gid_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of i_req at or above
// i_ptr, searching upward modulo N_REQ.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]               i_req,
  input  logic [gid_width(N_REQ)-1:0]    i_ptr,
  output logic [gid_width(N_REQ)-1:0]    o_winner,
  output logic                           o_any_valid
);

  localparam int GW = gid_width(N_REQ);

  logic [GW-1:0] w_idx;

  // Scan offsets from the pointer; the first valid channel wins.
  always_comb begin
    o_any_valid = 1'b0;
    o_winner    = '0;
    w_idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_idx = GW'((int'(i_ptr) + off) % N_REQ);
      if (!o_any_valid && i_req[w_idx]) begin
        o_any_valid = 1'b1;
        o_winner    = w_idx;
      end else begin
        o_any_valid = o_any_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART shifter from N_REQ byte sources.
// Define UART_TX_ARB_CHANNEL_TAG_EN to prefix every word with a channel tag frame.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_BITS-1:0]    req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          tx_start,
  output logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_busy,
  output logic [gid_width(N_REQ)-1:0]   grant_id,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int GW = gid_width(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  arb_state_e           r_state;
  logic                 r_arm;
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        r_grant;
  logic                 r_tx_start;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_busy;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;

  logic [GW-1:0]        w_winner;
  logic                 w_any;
  logic [GW-1:0]        w_next_ptr;
  logic [N_REQ-1:0]     w_ready;
  logic [DATA_BITS-1:0] w_sel_data;

`ifdef UART_TX_ARB_CHANNEL_TAG_EN
  logic [DATA_BITS-1:0] r_word;
  logic                 r_rose;
  logic [DATA_BITS-1:0] w_tag;

  if (DATA_BITS < GW + 1) begin : g_tag_width_check
    $error("uart_tx_arbiter: DATA_BITS too small to hold the channel tag");
  end

  // Tag word: marker in the MSB, winning channel index in the LSBs.
  always_comb begin
    w_tag              = '0;
    w_tag[DATA_BITS-1] = TAG_MARK;
    w_tag[GW-1:0]      = w_winner;
  end
`endif

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any)
  );

  assign w_sel_data = req_data[w_winner*DATA_BITS +: DATA_BITS];

  // r_arm keeps the accept pulse low while and just after nrst is asserted.
  always_comb begin
    w_ready = '0;
    if (r_arm && (r_state == ST_IDLE) && w_any) begin
      w_ready[w_winner] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Round-robin pointer advance with wrap at N_REQ.
  always_comb begin
    if (w_winner == GW'(N_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_winner + GW'(1);
    end
  end

  // Arbitration, frame sequencing and start-timeout supervision.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_arm      <= 1'b0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
`ifdef UART_TX_ARB_CHANNEL_TAG_EN
      r_word     <= '0;
      r_rose     <= 1'b0;
`endif
    end else begin
      r_arm <= 1'b1;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_arm && w_any) begin
            r_grant    <= w_winner;
            r_ptr      <= w_next_ptr;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
`ifdef UART_TX_ARB_CHANNEL_TAG_EN
            r_word     <= w_sel_data;
            r_tx_data  <= w_tag;
            r_state    <= ST_TAG_LOAD;
`else
            r_tx_data  <= w_sel_data;
            r_state    <= ST_LOAD;
`endif
          end
        end
`ifdef UART_TX_ARB_CHANNEL_TAG_EN
        ST_TAG_LOAD: begin
          r_tx_start <= 1'b0;
          r_cnt      <= '0;
          r_rose     <= 1'b0;
          r_state    <= ST_TAG_WAIT;
        end
        ST_TAG_WAIT: begin
          if (!r_rose) begin
            if (tx_busy) begin
              r_rose <= 1'b1;
            end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (!tx_busy) begin
            r_tx_data  <= r_word;
            r_tx_start <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
`endif
        ST_LOAD: begin
          r_tx_start <= 1'b0;
          r_cnt      <= '0;
          r_state    <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_FALL;
          end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_FALL: begin
          if (!tx_busy) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule
